// File: rtl/line_burst_responder_pkg.sv
// Line geometry and FSM encoding shared with the cache controller.
// Keeps burst length and column indexing defined in one place.
package line_burst_responder_pkg;

  localparam int BURST_LENGTH       = 4;
  localparam int COLUMN_IX_BITWIDTH = 2;
  localparam int ZEROS_BITWIDTH     = 2;
  localparam int LATENCY_BITWIDTH   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READ,
    WRITE
  } lbr_state_e;

  typedef logic [COLUMN_IX_BITWIDTH-1:0] col_ix_t;

  function automatic logic is_last_col(
    input col_ix_t col
  );
    return col == col_ix_t'(BURST_LENGTH - 1);
  endfunction

endpackage

// File: rtl/line_word_ram.sv
// Single-port synchronous word RAM, read-first, one-cycle read latency.
// Ports: clk, we, addr, wdata in; q out (registered read data).
module line_word_ram #(
  parameter int ADDRESS_BITWIDTH = 12
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [ADDRESS_BITWIDTH-1:0] addr,
  input  logic [31:0]                 wdata,
  output logic [31:0]                 q
);

  logic [31:0] mem [2**ADDRESS_BITWIDTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    q <= mem[addr];
  end

endmodule

// File: rtl/line_burst_responder.sv
// Backing-memory responder: 4-word line fills and write-backs after a
// fixed latency. Ports: cmd_* command handshake, wr_* write beats,
// rd_* fill beats, write_done pulse, busy status.
module line_burst_responder
  import line_burst_responder_pkg::*;
#(
  parameter int ADDRESS_BITWIDTH = 12,
  parameter int LATENCY          = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_address,
  input  logic [31:0] wr_data,
  input  logic        wr_data_valid,
  output logic        wr_data_ready,
  output logic [31:0] rd_data,
  output logic        rd_data_valid,
  output logic        rd_data_last,
  output logic        write_done,
  output logic        busy
);

  localparam int LINE_BITWIDTH =
    ADDRESS_BITWIDTH - COLUMN_IX_BITWIDTH;

  typedef logic [LATENCY_BITWIDTH-1:0] lat_t;

  lbr_state_e               state_q;
  lbr_state_e               state_d;
  logic [LINE_BITWIDTH-1:0] line_q;
  logic                     write_q;
  lat_t                     lat_q;
  col_ix_t                  beat_q;
  logic [2:0]               rd_cyc_q;
  logic                     rvalid_q;
  logic                     rlast_q;

  logic                     accept;
  logic                     ram_we;
  logic                     ram_re;
  logic                     ram_last;
  col_ix_t                  ram_col;
  logic [31:0]              ram_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{
    cmd_address[31:ADDRESS_BITWIDTH+ZEROS_BITWIDTH],
    cmd_address[COLUMN_IX_BITWIDTH+ZEROS_BITWIDTH-1:0]
  };

  assign cmd_ready     = state_q == IDLE;
  assign busy          = state_q != IDLE;
  assign wr_data_ready = (state_q == WRITE) && !write_done;
  assign accept        = cmd_valid && cmd_ready;

  always_comb begin
    state_d  = state_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_last = 1'b0;
    ram_col  = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid)
          state_d = WAIT;
      end
      WAIT: begin
        // Beat 0 is fetched during the last wait cycle so
        // the registered output lines up one edge later.
        if (lat_q == lat_t'(1)) begin
          state_d = write_q ? WRITE : READ;
          ram_re  = !write_q;
        end
      end
      READ: begin
        // Beats 1..3 are fetched on the first three read cycles.
        ram_re   = rd_cyc_q < 3'd3;
        ram_col  = col_ix_t'(rd_cyc_q[1:0] + 2'd1);
        ram_last = is_last_col(ram_col);
        if (rd_data_last)
          state_d = IDLE;
      end
      WRITE: begin
        if (!write_done && wr_data_valid) begin
          ram_we  = 1'b1;
          ram_col = beat_q;
        end
        if (write_done)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      line_q        <= '0;
      write_q       <= 1'b0;
      lat_q         <= '0;
      beat_q        <= '0;
      rd_cyc_q      <= '0;
      rvalid_q      <= 1'b0;
      rlast_q       <= 1'b0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      rd_data_last  <= 1'b0;
      write_done    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        line_q   <= cmd_address[ADDRESS_BITWIDTH+1:4];
        write_q  <= cmd_write;
        lat_q    <= lat_t'(LATENCY);
        rd_cyc_q <= '0;
        beat_q   <= '0;
      end else begin
        if (state_q == WAIT)
          lat_q <= lat_q - lat_t'(1);
        if (state_q == READ)
          rd_cyc_q <= rd_cyc_q + 3'd1;
        if (ram_we)
          beat_q <= beat_q + col_ix_t'(1);
      end
      write_done    <= ram_we && is_last_col(beat_q);
      rvalid_q      <= ram_re;
      rlast_q       <= ram_re && ram_last;
      rd_data_valid <= rvalid_q;
      rd_data_last  <= rlast_q;
      if (rvalid_q)
        rd_data <= ram_q;
    end
  end

  line_word_ram #(
    .ADDRESS_BITWIDTH(ADDRESS_BITWIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr ({line_q, ram_col}),
    .wdata(wr_data),
    .q    (ram_q)
  );

endmodule
